// File: rtl/drive_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// drive_cmd_sequencer
// Arbitrates manual and auto drive commands, ramping torque one level per step.
// Revision: 1.0
// ============================================================================
module drive_cmd_sequencer #(
  parameter int STEP_CYCLES = 12_500_000,
  parameter int DUR_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             estop,
  input  logic             man_valid,
  input  logic [1:0]       man_direc,
  input  logic [1:0]       man_torque,
  output logic             man_ready,
  input  logic             auto_valid,
  input  logic [1:0]       auto_direc,
  input  logic [1:0]       auto_torque,
  input  logic [DUR_W-1:0] auto_dur,
  output logic             auto_ready,
  output logic             auto_done,
  output logic             auto_abort,
  output logic             enable,
  output logic [1:0]       direc,
  output logic [1:0]       torque,
  output logic             busy
);

  localparam int CNT_W = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    HOLD      = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] step_cnt, step_cnt_n;
  logic [DUR_W-1:0] dur_cnt, dur_cnt_n;
  logic [1:0]       tgt_direc, tgt_direc_n;
  logic [1:0]       tgt_torque, tgt_torque_n;
  logic             src_auto, src_auto_n;
  logic             aborted, aborted_n;
  logic             enable_n, done_n, abort_n;
  logic [1:0]       direc_n, torque_n;
  logic             step;
  logic             man_same;

  assign step       = (step_cnt == STEP_LAST);
  assign man_ready  = (state == IDLE) && !estop && !reset;
  assign auto_ready = man_ready && !man_valid;
  assign busy       = (state != IDLE);
  assign man_same   = man_valid && (man_direc == tgt_direc) && (man_torque == tgt_torque);

  always_comb begin
    state_n      = state;
    dur_cnt_n    = dur_cnt;
    tgt_direc_n  = tgt_direc;
    tgt_torque_n = tgt_torque;
    src_auto_n   = src_auto;
    aborted_n    = aborted;
    enable_n     = enable;
    direc_n      = direc;
    torque_n     = torque;
    done_n       = 1'b0;
    abort_n      = 1'b0;
    // Step phase runs freely through all active states; only IDLE clears it.
    if (state == IDLE || step) begin
      step_cnt_n = '0;
    end else begin
      step_cnt_n = step_cnt + CNT_W'(1);
    end

    if (estop) begin
      state_n    = IDLE;
      torque_n   = 2'd0;
      enable_n   = 1'b0;
      step_cnt_n = '0;
    end else begin
      case (state)
        IDLE: begin
          if (man_valid && man_ready) begin
            tgt_direc_n  = man_direc;
            tgt_torque_n = man_torque;
            src_auto_n   = 1'b0;
            aborted_n    = 1'b0;
            direc_n      = man_direc;
            enable_n     = 1'b1;
            state_n      = RAMP_UP;
          end else if (auto_valid && auto_ready) begin
            tgt_direc_n  = auto_direc;
            tgt_torque_n = auto_torque;
            dur_cnt_n    = auto_dur;
            src_auto_n   = 1'b1;
            aborted_n    = 1'b0;
            direc_n      = auto_direc;
            enable_n     = 1'b1;
            state_n      = RAMP_UP;
          end
        end
        RAMP_UP: begin
          if (torque == tgt_torque) begin
            state_n = HOLD;
          end else if (step) begin
            torque_n = torque + 2'd1;
          end
        end
        HOLD: begin
          if (!src_auto) begin
            if (!man_same) begin
              state_n = RAMP_DOWN;
            end
          end else if (man_valid) begin
            state_n   = RAMP_DOWN;
            aborted_n = 1'b1;
          end else if (dur_cnt == '0) begin
            state_n = RAMP_DOWN;
          end else if (step) begin
            dur_cnt_n = dur_cnt - DUR_W'(1);
          end
        end
        RAMP_DOWN: begin
          if (torque == 2'd0) begin
            state_n  = IDLE;
            enable_n = 1'b0;
            done_n   = src_auto && !aborted;
            abort_n  = src_auto && aborted;
          end else if (step) begin
            torque_n = torque - 2'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      step_cnt   <= '0;
      dur_cnt    <= '0;
      tgt_direc  <= 2'd0;
      tgt_torque <= 2'd0;
      src_auto   <= 1'b0;
      aborted    <= 1'b0;
      enable     <= 1'b0;
      direc      <= 2'd0;
      torque     <= 2'd0;
      auto_done  <= 1'b0;
      auto_abort <= 1'b0;
    end else begin
      state      <= state_n;
      step_cnt   <= step_cnt_n;
      dur_cnt    <= dur_cnt_n;
      tgt_direc  <= tgt_direc_n;
      tgt_torque <= tgt_torque_n;
      src_auto   <= src_auto_n;
      aborted    <= aborted_n;
      enable     <= enable_n;
      direc      <= direc_n;
      torque     <= torque_n;
      auto_done  <= done_n;
      auto_abort <= abort_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_drive_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// tb_drive_cmd_sequencer
// Directed and random scenarios checked against a behavioural command model.
// Revision: 1.0
// ============================================================================
module tb_drive_cmd_sequencer;

  localparam int STEP = 4;
  localparam int DW   = 8;

  logic          clk = 1'b0;
  logic          reset, estop;
  logic          man_valid, auto_valid;
  logic [1:0]    man_direc, man_torque, auto_direc, auto_torque;
  logic [DW-1:0] auto_dur;
  logic          man_ready, auto_ready, auto_done, auto_abort;
  logic          enable, busy;
  logic [1:0]    direc, torque;

  int n_pass = 0;
  int n_total = 0;

  // Behavioural model: mode 0 idle, 1 rising, 2 holding, 3 falling.
  int         m_mode;
  int         m_elapsed;
  int         m_dur;
  logic       m_enable, m_auto, m_aborted, m_done, m_abt;
  logic [1:0] m_direc, m_torque, m_tgt_d, m_tgt_t;

  drive_cmd_sequencer #(.STEP_CYCLES(STEP), .DUR_W(DW)) dut (
    .clk(clk), .reset(reset), .estop(estop),
    .man_valid(man_valid), .man_direc(man_direc), .man_torque(man_torque),
    .man_ready(man_ready),
    .auto_valid(auto_valid), .auto_direc(auto_direc), .auto_torque(auto_torque),
    .auto_dur(auto_dur), .auto_ready(auto_ready),
    .auto_done(auto_done), .auto_abort(auto_abort),
    .enable(enable), .direc(direc), .torque(torque), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] dut_vec();
    return {enable, direc, torque, busy, auto_done, auto_abort, man_ready, auto_ready};
  endfunction

  function automatic logic [9:0] model_vec();
    logic mr, ar;
    mr = (m_mode == 0) && !estop && !reset;
    ar = mr && !man_valid;
    return {m_enable, m_direc, m_torque, m_mode != 0, m_done, m_abt, mr, ar};
  endfunction

  // A step lands every STEP cycles counted from the accept edge.
  task automatic model_step();
    bit stp;
    stp = (m_elapsed % STEP) == STEP - 1;
    m_done = 1'b0;
    m_abt  = 1'b0;
    if (reset) begin
      m_mode = 0; m_enable = 0; m_direc = 0; m_torque = 0;
      m_elapsed = 0; m_dur = 0; m_aborted = 0; m_auto = 0;
    end else if (estop) begin
      m_mode = 0; m_enable = 0; m_torque = 0; m_elapsed = 0;
    end else begin
      if (m_mode != 0) m_elapsed++;
      case (m_mode)
        0: begin
          if (man_valid || auto_valid) begin
            m_auto    = !man_valid;
            m_tgt_d   = man_valid ? man_direc : auto_direc;
            m_tgt_t   = man_valid ? man_torque : auto_torque;
            m_dur     = int'(auto_dur);
            m_direc   = m_tgt_d;
            m_enable  = 1;
            m_aborted = 0;
            m_elapsed = 0;
            m_mode    = 1;
          end
        end
        1: begin
          if (m_torque == m_tgt_t) m_mode = 2;
          else if (stp) m_torque = m_torque + 2'd1;
        end
        2: begin
          if (!m_auto) begin
            if (!(man_valid && man_direc == m_tgt_d && man_torque == m_tgt_t)) m_mode = 3;
          end else if (man_valid) begin
            m_mode = 3; m_aborted = 1;
          end else if (m_dur == 0) m_mode = 3;
          else if (stp) m_dur--;
        end
        default: begin
          if (m_torque == 0) begin
            m_mode = 0; m_enable = 0;
            m_done = m_auto && !m_aborted;
            m_abt  = m_auto && m_aborted;
          end else if (stp) m_torque = m_torque - 2'd1;
        end
      endcase
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    estop = 0; man_valid = 0; auto_valid = 0;
    man_direc = 0; man_torque = 0; auto_direc = 0; auto_torque = 0; auto_dur = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if (dut_vec() !== model_vec()) $display("FAIL reset cyc %0d: got %b want %b", i, dut_vec(), model_vec());
      else n_pass++;
    end
    reset = 0;
    tick();
    n_total++;
    if ({enable, direc, torque, busy} !== 6'b0) $display("FAIL reset_values: got %b want 000000", {enable, direc, torque, busy});
    else n_pass++;
  endtask

  task automatic test_auto_profile();
    int dones = 0;
    logic [1:0] peak = 0;
    auto_valid = 1; auto_direc = 2'b01; auto_torque = 3; auto_dur = 2;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (i == 0) auto_valid = 0;
      if (auto_done) dones++;
      if (torque > peak) peak = torque;
      n_total++;
      if (dut_vec() !== model_vec()) $display("FAIL auto_profile cyc %0d: got %b want %b", i, dut_vec(), model_vec());
      else n_pass++;
    end
    n_total++;
    if (dones != 1 || peak != 2'd3 || enable !== 1'b0)
      $display("FAIL auto_profile_summary: got done=%0d peak=%0d en=%b want 1 3 0", dones, peak, enable);
    else n_pass++;
  endtask

  task automatic test_abort();
    int aborts = 0;
    auto_valid = 1; auto_direc = 2'b00; auto_torque = 3; auto_dur = 10;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (i == 0) auto_valid = 0;
      if (i == 20) begin man_valid = 1; man_direc = 2'b10; man_torque = 2; end
      if (auto_abort) begin
        aborts++;
        n_total++;
        if (torque !== 2'd0) $display("FAIL abort_torque: got %0d want 0", torque);
        else n_pass++;
      end
      n_total++;
      if (dut_vec() !== model_vec()) $display("FAIL abort cyc %0d: got %b want %b", i, dut_vec(), model_vec());
      else n_pass++;
    end
    n_total++;
    if (aborts != 1 || direc !== 2'b10 || torque !== 2'd2)
      $display("FAIL abort_then_manual: got aborts=%0d direc=%b torque=%0d want 1 10 2", aborts, direc, torque);
    else n_pass++;
    man_valid = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_total++;
      if (dut_vec() !== model_vec()) $display("FAIL abort_drain cyc %0d: got %b want %b", i, dut_vec(), model_vec());
      else n_pass++;
    end
  endtask

  task automatic test_priority();
    bit auto_seen = 0;
    man_valid = 1; man_direc = 2'b01; man_torque = 1;
    auto_valid = 1; auto_direc = 2'b10; auto_torque = 2; auto_dur = 1;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (i == 10) man_valid = 0;
      if (m_mode != 0 && m_auto) begin auto_valid = 0; auto_seen = 1; end
      n_total++;
      if (dut_vec() !== model_vec()) $display("FAIL priority cyc %0d: got %b want %b", i, dut_vec(), model_vec());
      else n_pass++;
    end
    n_total++;
    if (!auto_seen || busy !== 1'b0) $display("FAIL priority_auto_after: got seen=%0d busy=%b want 1 0", auto_seen, busy);
    else n_pass++;
  endtask

  task automatic test_estop();
    auto_valid = 1; auto_direc = 2'b01; auto_torque = 3; auto_dur = 5;
    for (int i = 0; i < 40 && m_torque != 2; i++) begin
      tick();
      auto_valid = 0;
      n_total++;
      if (dut_vec() !== model_vec()) $display("FAIL estop_ramp cyc %0d: got %b want %b", i, dut_vec(), model_vec());
      else n_pass++;
    end
    estop = 1; man_valid = 1; man_direc = 2'b11; man_torque = 1; auto_valid = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_total++;
      if (dut_vec() !== model_vec()) $display("FAIL estop cyc %0d: got %b want %b", i, dut_vec(), model_vec());
      else n_pass++;
    end
    n_total++;
    if ({torque, enable, busy, man_ready, auto_ready} !== 6'b0 || direc !== 2'b01)
      $display("FAIL estop_blank: got t=%0d en=%b busy=%b mr=%b ar=%b d=%b want 0 0 0 0 0 01",
               torque, enable, busy, man_ready, auto_ready, direc);
    else n_pass++;
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      tick();
      n_total++;
      if (dut_vec() !== model_vec()) $display("FAIL estop_release cyc %0d: got %b want %b", i, dut_vec(), model_vec());
      else n_pass++;
    end
  endtask

  task automatic test_man_zero();
    man_valid = 1; man_direc = 2'b11; man_torque = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_total++;
      if (dut_vec() !== model_vec()) $display("FAIL man_zero cyc %0d: got %b want %b", i, dut_vec(), model_vec());
      else n_pass++;
    end
    man_valid = 0;
    tick();
    tick();
    n_total++;
    if (busy !== 1'b0 || enable !== 1'b0 || direc !== 2'b11)
      $display("FAIL man_zero_release: got busy=%b en=%b direc=%b want 0 0 11", busy, enable, direc);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    auto_valid = 1; auto_direc = 2'b10; auto_torque = 3; auto_dur = 10;
    for (int i = 0; i < 20; i++) begin
      tick();
      auto_valid = 0;
      n_total++;
      if (dut_vec() !== model_vec()) $display("FAIL reset_mid_run cyc %0d: got %b want %b", i, dut_vec(), model_vec());
      else n_pass++;
    end
    reset = 1;
    tick();
    reset = 0;
    n_total++;
    if ({enable, direc, torque, busy, auto_done, auto_abort} !== 8'b0)
      $display("FAIL reset_mid: got %b want 00000000", {enable, direc, torque, busy, auto_done, auto_abort});
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_total++;
      if (dut_vec() !== model_vec()) $display("FAIL reset_mid_after cyc %0d: got %b want %b", i, dut_vec(), model_vec());
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      estop = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 29) == 0) man_valid = !man_valid;
      if ($urandom_range(0, 39) == 0) begin
        man_direc  = 2'($urandom_range(0, 3));
        man_torque = 2'($urandom_range(0, 3));
      end
      auto_valid  = ($urandom_range(0, 3) == 0);
      auto_direc  = 2'($urandom_range(0, 3));
      auto_torque = 2'($urandom_range(0, 3));
      auto_dur    = DW'($urandom_range(0, 5));
      tick();
      n_total++;
      if (dut_vec() !== model_vec()) $display("FAIL random cyc %0d: got %b want %b", i, dut_vec(), model_vec());
      else n_pass++;
    end
    idle_inputs();
    reset = 0;
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    m_mode = 0; m_elapsed = 0; m_dur = 0; m_enable = 0; m_auto = 0;
    m_aborted = 0; m_done = 0; m_abt = 0; m_direc = 0; m_torque = 0;
    m_tgt_d = 0; m_tgt_t = 0;
    test_reset();
    test_auto_profile();
    test_abort();
    test_priority();
    test_estop();
    test_man_zero();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
